inertial_integrator: RTL



---
 rtl/inertial_pkg.sv | 17 +
 rtl/axis_integ.sv | 75 +++++++
 rtl/inertial_integrator.sv | 89 ++++++++
 3 files changed

// File: rtl/inertial_pkg.sv
// Shared types and constants for the inertial integrator.
package inertial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int INT_W   = 27;
    localparam int OUT_MSB = 26;
    localparam int OUT_LSB = 11;

    localparam int FUSION_STEP_DEF = 1024;
    localparam int ACC_SCALE_DEF   = 327;

endpackage

// File: rtl/axis_integ.sv
// One axis: offset calibration accumulator, offset register, rate integrator
// and optional complementary fusion toward the accelerometer angle.
module axis_integ
    import inertial_pkg::*;
#(
    parameter int CAL_SHIFT   = 3,
    parameter int FUSE_EN     = 1,
    parameter int FUSION_STEP = FUSION_STEP_DEF,
    parameter int ACC_SCALE   = ACC_SCALE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cal_clr,
    input  logic               cal_add,
    input  logic               cal_load,
    input  logic               run_upd,
    input  logic signed [15:0] rate,
    input  logic signed [15:0] accel,
    output logic signed [15:0] angle
);

    localparam int ACC_W = 16 + CAL_SHIFT;

    logic signed [ACC_W-1:0] cal_acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [15:0]      offset;
    logic signed [INT_W-1:0] integ;
    logic signed [INT_W-1:0] integ_next;
    logic signed [INT_W-1:0] fuse;
    logic signed [16:0]      diff;
    logic signed [24:0]      prod;
    logic signed [15:0]      acc_ang;

    assign acc_sum = cal_acc + ACC_W'(rate);
    assign diff    = {rate[15], rate} - {offset[15], offset};
    assign prod    = 25'(accel * ACC_SCALE);
    // Value of prod >>> 13 fits in 12 bits, so the 16-bit cast keeps its sign.
    assign acc_ang = 16'(prod >>> 13);
    assign angle   = integ[OUT_MSB:OUT_LSB];

    // Fixed-step pull of the output toward the accelerometer angle.
    always_comb begin
        fuse = '0;
        if (FUSE_EN != 0) begin
            if (acc_ang > angle)
                fuse = INT_W'(FUSION_STEP);
            else if (acc_ang < angle)
                fuse = -INT_W'(FUSION_STEP);
        end
    end

    assign integ_next = integ - INT_W'(diff) + fuse;

    // Calibration accumulation, offset capture and integration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_acc <= '0;
            offset  <= '0;
            integ   <= '0;
        end else if (cal_clr) begin
            cal_acc <= '0;
            integ   <= '0;
        end else begin
            if (cal_add)
                cal_acc <= acc_sum;
            if (cal_load) begin
                offset <= 16'(acc_sum >>> CAL_SHIFT);
                integ  <= '0;
            end else if (run_upd) begin
                integ <= integ_next;
            end
        end
    end

endmodule

// File: rtl/inertial_integrator.sv
// Top level: calibration/run FSM, sample counter and output strobes around
// three per-axis integrators (yaw without accelerometer fusion).
module inertial_integrator
    import inertial_pkg::*;
#(
    parameter int CAL_SHIFT   = 3,
    parameter int FUSION_STEP = FUSION_STEP_DEF,
    parameter int ACC_SCALE   = ACC_SCALE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               strt_cal,
    input  logic signed [15:0] ptch_rt,
    input  logic signed [15:0] roll_rt,
    input  logic signed [15:0] yaw_rt,
    input  logic signed [15:0] ax,
    input  logic signed [15:0] ay,
    output logic signed [15:0] ptch,
    output logic signed [15:0] roll,
    output logic signed [15:0] yaw,
    output logic               vld_out,
    output logic               cal_done
);

    state_t               state, nxt_state;
    logic [CAL_SHIFT-1:0] cnt;
    logic                 cnt_last;
    logic                 cal_clr, cal_add, cal_load, run_upd;

    assign cnt_last = (cnt == {CAL_SHIFT{1'b1}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    // Next state: strt_cal from anywhere wins over vld.
    always_comb begin
        nxt_state = state;
        if (strt_cal)
            nxt_state = CAL;
        else if (state == CAL && vld && cnt_last)
            nxt_state = RUN;
    end

    // Datapath controls decoded from state and inputs.
    always_comb begin
        cal_clr  = strt_cal;
        cal_add  = (state == CAL) && vld && !strt_cal;
        cal_load = cal_add && cnt_last;
        run_upd  = (state == RUN) && vld && !strt_cal;
    end

    // Calibration sample counter; wraps to 0 on the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (cal_clr) cnt <= '0;
        else if (cal_add) cnt <= cnt + 1'b1;
    end

    // Output strobes, aligned with the updated integrators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_out  <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            vld_out  <= run_upd;
            cal_done <= cal_load;
        end
    end

    axis_integ #(.CAL_SHIFT(CAL_SHIFT), .FUSE_EN(1), .FUSION_STEP(FUSION_STEP), .ACC_SCALE(ACC_SCALE)) u_ptch (
        .clk(clk), .rst_n(rst_n), .cal_clr(cal_clr), .cal_add(cal_add), .cal_load(cal_load),
        .run_upd(run_upd), .rate(ptch_rt), .accel(ay), .angle(ptch)
    );

    axis_integ #(.CAL_SHIFT(CAL_SHIFT), .FUSE_EN(1), .FUSION_STEP(FUSION_STEP), .ACC_SCALE(ACC_SCALE)) u_roll (
        .clk(clk), .rst_n(rst_n), .cal_clr(cal_clr), .cal_add(cal_add), .cal_load(cal_load),
        .run_upd(run_upd), .rate(roll_rt), .accel(ax), .angle(roll)
    );

    axis_integ #(.CAL_SHIFT(CAL_SHIFT), .FUSE_EN(0), .FUSION_STEP(FUSION_STEP), .ACC_SCALE(ACC_SCALE)) u_yaw (
        .clk(clk), .rst_n(rst_n), .cal_clr(cal_clr), .cal_add(cal_add), .cal_load(cal_load),
        .run_upd(run_upd), .rate(yaw_rt), .accel(16'sd0), .angle(yaw)
    );

endmodule
